// File: rtl/calc_key_entry.sv
// Keypad calculator front end: registers the first pressed key, then runs the
// A / operator / B / '=' entry FSM with add, subtract, multiply and iterative divide.
module calc_key_entry #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WIDTH  = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      key_pulse,
  output logic             key_valid,
  output logic [3:0]       key_code,
  output logic [WIDTH-1:0] disp_value,
  output logic             disp_neg,
  output logic             disp_err,
  output logic             busy
);

  localparam int unsigned LIM = 10**DIGITS - 1;
  localparam int unsigned CW  = $clog2(DIGITS + 1);
  localparam int unsigned DW  = $clog2(WIDTH);
  localparam logic [2*WIDTH-1:0] LIM_W = (2*WIDTH)'(LIM);

  typedef enum logic [2:0] {S_A, S_OP, S_B, S_CALC, S_RES, S_ERR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t           state;
  op_t              op_r;
  logic [WIDTH-1:0] a_r, b_r, quo_r, rem_r;
  logic [CW-1:0]    cnt_r;
  logic [DW-1:0]    div_cnt;
  logic             div_run;

  logic [3:0] first_idx;
  logic       found;
  always_comb begin
    first_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (key_pulse[i] && !found) begin
        first_idx = 4'(i);
        found     = 1'b1;
      end
    end
  end

  logic       is_digit, is_op, is_clr, is_eq;
  logic [3:0] digit;
  op_t        key_op;
  always_comb begin
    is_digit = 1'b0;
    is_op    = 1'b0;
    is_clr   = 1'b0;
    is_eq    = 1'b0;
    digit    = '0;
    key_op   = OP_ADD;
    case (key_code)
      4'd0:  begin is_digit = 1'b1; digit = 4'd1; end
      4'd1:  begin is_digit = 1'b1; digit = 4'd2; end
      4'd2:  begin is_digit = 1'b1; digit = 4'd3; end
      4'd3:  begin is_op = 1'b1; key_op = OP_ADD; end
      4'd4:  begin is_digit = 1'b1; digit = 4'd4; end
      4'd5:  begin is_digit = 1'b1; digit = 4'd5; end
      4'd6:  begin is_digit = 1'b1; digit = 4'd6; end
      4'd7:  begin is_op = 1'b1; key_op = OP_SUB; end
      4'd8:  begin is_digit = 1'b1; digit = 4'd7; end
      4'd9:  begin is_digit = 1'b1; digit = 4'd8; end
      4'd10: begin is_digit = 1'b1; digit = 4'd9; end
      4'd11: begin is_op = 1'b1; key_op = OP_MUL; end
      4'd12: is_clr = 1'b1;
      4'd13: begin is_digit = 1'b1; digit = 4'd0; end
      4'd14: is_eq = 1'b1;
      default: begin is_op = 1'b1; key_op = OP_DIV; end
    endcase
  end

  logic [WIDTH-1:0]   acc_a, acc_b, digit_w;
  logic [2*WIDTH-1:0] sum_w, prod_w;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next, quo_next;
  logic               can_acc_a, can_acc_b;
  always_comb begin
    digit_w   = WIDTH'(digit);
    acc_a     = WIDTH'(a_r * 10 + digit_w);
    acc_b     = WIDTH'(b_r * 10 + digit_w);
    // a leading zero on an empty operand consumes no digit slot
    can_acc_a = (cnt_r < CW'(DIGITS)) && !(digit == 4'd0 && a_r == '0);
    can_acc_b = (cnt_r < CW'(DIGITS)) && !(digit == 4'd0 && b_r == '0);
    sum_w     = (2*WIDTH)'(a_r) + (2*WIDTH)'(b_r);
    prod_w    = (2*WIDTH)'(a_r) * (2*WIDTH)'(b_r);
    div_trial = {rem_r, quo_r[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, b_r};
    rem_next  = div_ge ? WIDTH'(div_trial - {1'b0, b_r}) : div_trial[WIDTH-1:0];
    quo_next  = {quo_r[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_A;
      op_r       <= OP_ADD;
      a_r        <= '0;
      b_r        <= '0;
      quo_r      <= '0;
      rem_r      <= '0;
      cnt_r      <= '0;
      div_cnt    <= '0;
      div_run    <= 1'b0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      disp_value <= '0;
      disp_neg   <= 1'b0;
      disp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      key_valid <= |key_pulse;
      if (|key_pulse) key_code <= first_idx;

      if (key_valid && is_clr) begin
        state      <= S_A;
        a_r        <= '0;
        b_r        <= '0;
        cnt_r      <= '0;
        div_run    <= 1'b0;
        disp_value <= '0;
        disp_neg   <= 1'b0;
        disp_err   <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_A: if (key_valid) begin
            if (is_digit && can_acc_a) begin
              a_r        <= acc_a;
              cnt_r      <= cnt_r + CW'(1);
              disp_value <= acc_a;
            end else if (is_op) begin
              op_r  <= key_op;
              state <= S_OP;
            end
          end
          S_OP: if (key_valid) begin
            if (is_digit) begin
              b_r        <= digit_w;
              cnt_r      <= CW'(digit != 4'd0);
              disp_value <= digit_w;
              state      <= S_B;
            end else if (is_op) begin
              op_r <= key_op;
            end
          end
          S_B: if (key_valid) begin
            if (is_digit && can_acc_b) begin
              b_r        <= acc_b;
              cnt_r      <= cnt_r + CW'(1);
              disp_value <= acc_b;
            end else if (is_eq) begin
              state <= S_CALC;
              busy  <= 1'b1;
            end
          end
          S_CALC: if (!div_run) begin
            case (op_r)
              OP_ADD, OP_MUL: begin
                busy <= 1'b0;
                if (((op_r == OP_ADD) ? sum_w : prod_w) > LIM_W) begin
                  state      <= S_ERR;
                  disp_value <= '0;
                  disp_err   <= 1'b1;
                end else begin
                  state      <= S_RES;
                  disp_value <= WIDTH'((op_r == OP_ADD) ? sum_w : prod_w);
                end
              end
              OP_SUB: begin
                busy       <= 1'b0;
                state      <= S_RES;
                disp_value <= (a_r >= b_r) ? a_r - b_r : b_r - a_r;
                disp_neg   <= a_r < b_r;
              end
              default: begin
                if (b_r == '0) begin
                  busy       <= 1'b0;
                  state      <= S_ERR;
                  disp_value <= '0;
                  disp_err   <= 1'b1;
                end else begin
                  div_run <= 1'b1;
                  div_cnt <= '0;
                  quo_r   <= a_r;
                  rem_r   <= '0;
                end
              end
            endcase
          end else begin
            // restoring divide: one quotient bit per cycle, MSB first
            quo_r   <= quo_next;
            rem_r   <= rem_next;
            div_cnt <= div_cnt + DW'(1);
            if (div_cnt == DW'(WIDTH - 1)) begin
              div_run    <= 1'b0;
              busy       <= 1'b0;
              state      <= S_RES;
              disp_value <= quo_next;
            end
          end
          S_RES: if (key_valid) begin
            if (is_digit) begin
              a_r        <= digit_w;
              cnt_r      <= CW'(digit != 4'd0);
              disp_value <= digit_w;
              disp_neg   <= 1'b0;
              state      <= S_A;
            end else if (is_op && !disp_neg) begin
              a_r   <= disp_value;
              op_r  <= key_op;
              state <= S_OP;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed keypad sequences; a scoreboard checks each accepted key and each
// completed calculation against hand-computed values.
module tb_calc_key_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] key_pulse = '0;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [13:0] disp_value;
  logic        disp_neg, disp_err, busy;

  calc_key_entry #(.DIGITS(4), .WIDTH(14)) dut (
    .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse),
    .key_valid(key_valid), .key_code(key_code), .disp_value(disp_value),
    .disp_neg(disp_neg), .disp_err(disp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int code; int disp; int neg; int err; int busy; } key_exp_t;
  typedef struct { int disp; int neg; int err; int cycles; } res_exp_t;

  key_exp_t kq[$];
  res_exp_t rq[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic press_raw(input logic [15:0] pulse, input int code, input int disp,
                           input int neg, input int err, input int bsy);
    key_exp_t e;
    e.code = code; e.disp = disp; e.neg = neg; e.err = err; e.busy = bsy;
    kq.push_back(e);
    @(posedge clk); #1 key_pulse = pulse;
    @(posedge clk); #1 key_pulse = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic press(input int idx, input int disp, input int neg = 0,
                       input int err = 0, input int bsy = 0);
    logic [15:0] p;
    p = 16'd1 << idx;
    press_raw(p, idx, disp, neg, err, bsy);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(posedge clk);
    if (busy) check("busy_timeout", 1, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic equals(input int disp_before, input int r_disp, input int r_neg,
                        input int r_err, input int cycles);
    res_exp_t r;
    r.disp = r_disp; r.neg = r_neg; r.err = r_err; r.cycles = cycles;
    rq.push_back(r);
    press(14, disp_before, 0, 0, 1);
    wait_idle();
  endtask

  // key monitor: code one cycle after the press, display the cycle after that
  initial begin
    key_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && key_valid) begin
        if (kq.size() == 0) begin
          check("unexpected_key", 1, 0);
        end else begin
          e = kq.pop_front();
          check("key_code", int'(key_code), e.code);
          @(negedge clk);
          check("key_disp", int'(disp_value), e.disp);
          check("key_neg", int'(disp_neg), e.neg);
          check("key_err", int'(disp_err), e.err);
          check("key_busy", int'(busy), e.busy);
        end
      end
    end
  end

  // result monitor: fires when busy falls
  initial begin
    res_exp_t r;
    int   cyc;
    logic prev;
    cyc = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0;
        prev = 1'b0;
      end else begin
        if (busy) cyc++;
        else if (prev) begin
          if (rq.size() == 0) check("unexpected_result", 1, 0);
          else begin
            r = rq.pop_front();
            check("res_disp", int'(disp_value), r.disp);
            check("res_neg", int'(disp_neg), r.neg);
            check("res_err", int'(disp_err), r.err);
            if (r.cycles > 0) check("res_busy_cycles", cyc, r.cycles);
          end
          cyc = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    check("rst_valid", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_disp", int'(disp_value), 0);
    check("rst_flags", int'({disp_neg, disp_err, busy}), 0);
    @(negedge clk) rst_n = 1'b1;

    // 12 + 34 = 46
    press(0, 1); press(1, 12); press(3, 12); press(2, 3); press(4, 34);
    equals(34, 46, 0, 0, 1);
    // 5 - 9 = -4, then operator ignored on a negative result
    press(5, 5); press(7, 5); press(10, 9);
    equals(9, 4, 1, 0, 1);
    press(3, 4, 1, 0, 0);
    // digit limit, multiply overflow, error lock, clear
    press(10, 9); press(10, 99); press(10, 999); press(10, 9999); press(10, 9999);
    press(11, 9999); press(1, 2);
    equals(2, 0, 0, 1, 1);
    press(8, 0, 0, 1, 0);
    press(12, 0);
    // 100 / 7 = 14, then divide by zero
    press(0, 1); press(13, 10); press(13, 100); press(15, 100); press(8, 7);
    equals(7, 14, 0, 0, 15);
    press(12, 0); press(9, 8); press(15, 8); press(13, 0);
    equals(0, 0, 0, 1, 1);
    // multi-key priority, clear aborts a divide
    press(12, 0);
    press_raw(16'h0011, 0, 1, 0, 0, 0);
    press(15, 1); press(2, 3);
    begin
      res_exp_t r;
      r.disp = 0; r.neg = 0; r.err = 0; r.cycles = 0;
      rq.push_back(r);
    end
    press(14, 3, 0, 0, 1);
    press_raw(16'h1000, 12, 0, 0, 0, 0);
    wait_idle();
    // chained result, then async reset mid-entry
    press(12, 0); press(6, 6); press(11, 6); press(8, 7);
    equals(7, 42, 0, 0, 1);
    press(3, 42); press(9, 8);
    equals(8, 50, 0, 0, 1);
    press(0, 1); press(1, 12);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(key_valid), 0);
    check("arst_code", int'(key_code), 0);
    check("arst_disp", int'(disp_value), 0);
    check("arst_flags", int'({disp_neg, disp_err, busy}), 0);
    @(negedge clk) rst_n = 1'b1;
    press(4, 4);

    repeat (5) @(posedge clk);
    check("key_queue_empty", kq.size(), 0);
    check("res_queue_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
